// File: rtl/piso_shift_if.sv
// Parallel-load / serial-out bus for piso_shift. The done flag exists only
// when PISO_SHIFT_DONE_EN is defined.
interface piso_shift_if #(
  parameter int INPUT_WIDTH = 8
);
  logic                   shift_load;
  logic [INPUT_WIDTH-1:0] data;
  logic                   serial_out;
`ifdef PISO_SHIFT_DONE_EN
  logic                   done;

  modport master (
    output shift_load,
    output data,
    input  serial_out,
    input  done
  );

  modport slave (
    input  shift_load,
    input  data,
    output serial_out,
    output done
  );
`else
  modport master (
    output shift_load,
    output data,
    input  serial_out
  );

  modport slave (
    input  shift_load,
    input  data,
    output serial_out
  );
`endif
endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, LSB-first (SHIFT_LEFT=0) or MSB-first (SHIFT_LEFT=1).
// Optional end-of-word flag 'done' is built when PISO_SHIFT_DONE_EN is defined.
module piso_shift #(
  parameter int   INPUT_WIDTH = 8,
  parameter logic VALUE_PULL  = 1'b1,
  parameter int   SHIFT_LEFT  = 0
) (
  input logic         clk,
  input logic         rst_n,
  piso_shift_if.slave bus
);

  logic [INPUT_WIDTH-1:0] sr_r;
  logic [INPUT_WIDTH-1:0] sr_next_s;

  // Next shift-register value: a load always wins over a shift
  always_comb begin
    sr_next_s = sr_r;
    if (bus.shift_load) begin
      sr_next_s = bus.data;
    end else if (SHIFT_LEFT != 0) begin
      sr_next_s = {sr_r[INPUT_WIDTH-2:0], VALUE_PULL};
    end else begin
      sr_next_s = {VALUE_PULL, sr_r[INPUT_WIDTH-1:1]};
    end
  end

  // Shift register; reset fills it with the pull value so the line idles there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= {INPUT_WIDTH{VALUE_PULL}};
    end else begin
      sr_r <= sr_next_s;
    end
  end

  // Serial bit is taken straight from the register so it tracks async reset
  assign bus.serial_out = (SHIFT_LEFT != 0) ? sr_r[INPUT_WIDTH-1] : sr_r[0];

`ifdef PISO_SHIFT_DONE_EN
  localparam int                 CNT_W   = $clog2(INPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(INPUT_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             done_r;

  // Shift counter: cleared by load, saturates once every bit has been presented
  always_comb begin
    cnt_next_s = cnt_r;
    if (bus.shift_load) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter and flag; done is precomputed from the next count to stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_MAX;
      done_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_next_s;
      done_r <= (cnt_next_s == CNT_MAX);
    end
  end

  assign bus.done = done_r;
`endif

endmodule

// File: tb/tb_piso_shift.sv
// Directed bench for piso_shift: right, left and zero-fill instances share stimulus.
module tb_piso_shift;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       load  = 1'b0;
  logic [7:0] din   = 8'h00;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  piso_shift_if #(.INPUT_WIDTH(8)) bus_r ();
  piso_shift_if #(.INPUT_WIDTH(8)) bus_l ();
  piso_shift_if #(.INPUT_WIDTH(8)) bus_z ();

  assign bus_r.shift_load = load;
  assign bus_r.data       = din;
  assign bus_l.shift_load = load;
  assign bus_l.data       = din;
  assign bus_z.shift_load = load;
  assign bus_z.data       = din;

  piso_shift #(.INPUT_WIDTH(8), .VALUE_PULL(1'b1), .SHIFT_LEFT(0)) u_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  piso_shift #(.INPUT_WIDTH(8), .VALUE_PULL(1'b1), .SHIFT_LEFT(1)) u_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
  piso_shift #(.INPUT_WIDTH(8), .VALUE_PULL(1'b0), .SHIFT_LEFT(0)) u_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (bus_r.serial_out !== 1'b1) begin bad++; $display("FAIL reset_async_r: got %b want 1", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL reset_async_l: got %b want 1", bus_l.serial_out); end
    if (bus_z.serial_out !== 1'b0) begin bad++; $display("FAIL reset_async_z: got %b want 0", bus_z.serial_out); end
    // load requested while reset is held must be ignored
    din  = 8'h00;
    load = 1'b1;
    step();
    step();
    total += 2;
    if (bus_r.serial_out !== 1'b1) begin bad++; $display("FAIL reset_hold_r: got %b want 1", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL reset_hold_l: got %b want 1", bus_l.serial_out); end
`ifdef PISO_SHIFT_DONE_EN
    total += 1;
    if (bus_r.done !== 1'b1) begin bad++; $display("FAIL reset_done: got %b want 1", bus_r.done); end
`endif
    load = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  // seq_r / seq_l list the expected serial bits first-to-last from MSB down
  task automatic test_word(input string name, input logic [7:0] w,
                           input logic [7:0] seq_r, input logic [7:0] seq_l);
    din  = w;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total += 3;
      if (bus_r.serial_out !== seq_r[7-i]) begin bad++; $display("FAIL %s_r bit%0d: got %b want %b", name, i, bus_r.serial_out, seq_r[7-i]); end
      if (bus_l.serial_out !== seq_l[7-i]) begin bad++; $display("FAIL %s_l bit%0d: got %b want %b", name, i, bus_l.serial_out, seq_l[7-i]); end
      if (bus_z.serial_out !== seq_r[7-i]) begin bad++; $display("FAIL %s_z bit%0d: got %b want %b", name, i, bus_z.serial_out, seq_r[7-i]); end
`ifdef PISO_SHIFT_DONE_EN
      total += 1;
      if (bus_r.done !== 1'b0) begin bad++; $display("FAIL %s_done bit%0d: got %b want 0", name, i, bus_r.done); end
`endif
      step();
    end
    for (int k = 0; k < 3; k++) begin
      total += 3;
      if (bus_r.serial_out !== 1'b1) begin bad++; $display("FAIL %s_fill_r %0d: got %b want 1", name, k, bus_r.serial_out); end
      if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL %s_fill_l %0d: got %b want 1", name, k, bus_l.serial_out); end
      if (bus_z.serial_out !== 1'b0) begin bad++; $display("FAIL %s_fill_z %0d: got %b want 0", name, k, bus_z.serial_out); end
`ifdef PISO_SHIFT_DONE_EN
      total += 1;
      if (bus_r.done !== 1'b1) begin bad++; $display("FAIL %s_done_fill %0d: got %b want 1", name, k, bus_r.done); end
`endif
      step();
    end
  endtask

  task automatic test_reload();
    din  = 8'hFF;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    din  = 8'h00;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total += 2;
      if (bus_r.serial_out !== 1'b0) begin bad++; $display("FAIL reload_r bit%0d: got %b want 0", i, bus_r.serial_out); end
      if (bus_l.serial_out !== 1'b0) begin bad++; $display("FAIL reload_l bit%0d: got %b want 0", i, bus_l.serial_out); end
      step();
    end
    total += 2;
    if (bus_r.serial_out !== 1'b1) begin bad++; $display("FAIL reload_fill_r: got %b want 1", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL reload_fill_l: got %b want 1", bus_l.serial_out); end
  endtask

  task automatic test_async_reset(input logic [7:0] w);
    din  = w;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (bus_r.serial_out !== 1'b1) begin bad++; $display("FAIL midreset_r %h: got %b want 1", w, bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL midreset_l %h: got %b want 1", w, bus_l.serial_out); end
    if (bus_z.serial_out !== 1'b0) begin bad++; $display("FAIL midreset_z %h: got %b want 0", w, bus_z.serial_out); end
`ifdef PISO_SHIFT_DONE_EN
    total += 1;
    if (bus_r.done !== 1'b1) begin bad++; $display("FAIL midreset_done %h: got %b want 1", w, bus_r.done); end
`endif
    #1 rst_n = 1'b1;
    din  = 8'h5A;
    load = 1'b1;
    step();
    load = 1'b0;
    total += 2;
    if (bus_r.serial_out !== 1'b0) begin bad++; $display("FAIL first_edge_load_r: got %b want 0", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b0) begin bad++; $display("FAIL first_edge_load_l: got %b want 0", bus_l.serial_out); end
  endtask

  task automatic test_hold_load();
    din  = 8'h02;
    load = 1'b1;
    step();
    din  = 8'h84;
    step();
    load = 1'b0;
    total += 2;
    if (bus_r.serial_out !== 1'b0) begin bad++; $display("FAIL hold_load_r: got %b want 0", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b1) begin bad++; $display("FAIL hold_load_l: got %b want 1", bus_l.serial_out); end
`ifdef PISO_SHIFT_DONE_EN
    total += 1;
    if (bus_r.done !== 1'b0) begin bad++; $display("FAIL hold_load_done: got %b want 0", bus_r.done); end
`endif
  endtask

  task automatic test_between_edges();
    din  = 8'b11011000;
    load = 1'b1;
    step();
    load = 1'b0;
    #2 load = 1'b1;
    din  = 8'hFF;
    #2 load = 1'b0;
    din  = 8'h00;
    step();
    total += 1;
    if (bus_r.serial_out !== 1'b0) begin bad++; $display("FAIL glitch_r shift1: got %b want 0", bus_r.serial_out); end
    step();
    total += 2;
    if (bus_r.serial_out !== 1'b0) begin bad++; $display("FAIL glitch_r shift2: got %b want 0", bus_r.serial_out); end
    if (bus_l.serial_out !== 1'b0) begin bad++; $display("FAIL glitch_l shift2: got %b want 0", bus_l.serial_out); end
  endtask

  task automatic test_fill_zero();
    din  = 8'hFF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total += 1;
      if (bus_z.serial_out !== 1'b1) begin bad++; $display("FAIL fill_zero bit%0d: got %b want 1", i, bus_z.serial_out); end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      total += 1;
      if (bus_z.serial_out !== 1'b0) begin bad++; $display("FAIL fill_zero_tail %0d: got %b want 0", k, bus_z.serial_out); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_word("first",  8'b11011000, 8'b00011011, 8'b11011000);
    test_word("second", 8'b00101000, 8'b00010100, 8'b00101000);
    test_reload();
    test_async_reset(8'hFF);
    test_async_reset(8'h00);
    test_hold_load();
    test_between_edges();
    test_fill_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
